// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the issuing stage and the ALU / multiply-divide unit.
// The master issues instructions and consumes results; the slave is the execution unit.
interface alu_muldiv_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_out;
  logic [2:0]       flags;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, instruction, op_a, op_b, out_ready,
    input  in_ready, out_valid, result_out, flags, illegal, hi, lo
  );

  modport slave (
    input  in_valid, instruction, op_a, op_b, out_ready,
    output in_ready, out_valid, result_out, flags, illegal, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS-style ALU with iterative shift-add multiplier and restoring divider sharing one HI/LO pair.
//
//   state | meaning
//   IDLE  | ready for a request; single-cycle ops resolve here
//   MUL   | WIDTH shift-add iterations, last one writes HI/LO
//   DIV   | WIDTH restoring-divide iterations, last one writes HI/LO
//   DONE  | result held until out_valid && out_ready
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [1:0] {K_ALU, K_MUL, K_DIV} kind_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] work_hi, work_lo, operand, dividend;
  logic             neg_lo, neg_hi, div_zero, div_ovf;
  logic             in_ready_q, out_valid_q, illegal_q;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic [2:0]       flags_q;

  logic [5:0]       opcode, funct;
  logic [4:0]       shamt;
  logic [15:0]      imm;
  logic [WIDTH-1:0] a, b, simm, zimm;
  logic [CW-1:0]    vamt;
  logic             unused_rs_rt;

  assign opcode       = bus.instruction[31:26];
  assign funct        = bus.instruction[5:0];
  assign shamt        = bus.instruction[10:6];
  assign imm          = bus.instruction[15:0];
  assign unused_rs_rt = ^bus.instruction[25:16];
  assign a            = bus.op_a;
  assign b            = bus.op_b;
  assign simm         = WIDTH'($signed(imm));
  assign zimm         = WIDTH'(imm);
  assign vamt         = a[CW-1:0];

  logic [WIDTH-1:0] add_res, sub_res, addi_res;
  logic             add_ovf, sub_ovf, addi_ovf;

  assign add_res  = a + b;
  assign sub_res  = a - b;
  assign addi_res = a + simm;
  assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1])    && (add_res[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1])    && (sub_res[WIDTH-1]  != a[WIDTH-1]);
  assign addi_ovf = (a[WIDTH-1] == simm[WIDTH-1]) && (addi_res[WIDTH-1] != a[WIDTH-1]);

  kind_t            kind;
  logic             is_signed, alu_ovf, alu_cmp, alu_is_cmp, alu_ill;
  logic [WIDTH-1:0] alu_res;
  logic [2:0]       alu_flags;

  always_comb begin
    kind       = K_ALU;
    is_signed  = 1'b0;
    alu_res    = '0;
    alu_ovf    = 1'b0;
    alu_cmp    = 1'b0;
    alu_is_cmp = 1'b0;
    alu_ill    = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20: begin alu_res = add_res; alu_ovf = add_ovf; end
        6'h21: alu_res = add_res;
        6'h22: begin alu_res = sub_res; alu_ovf = sub_ovf; end
        6'h23: alu_res = sub_res;
        6'h24: alu_res = a & b;
        6'h25: alu_res = a | b;
        6'h26: alu_res = a ^ b;
        6'h27: alu_res = ~(a | b);
        6'h2A: begin alu_is_cmp = 1'b1; alu_cmp = $signed(a) < $signed(b); alu_res = WIDTH'(alu_cmp); end
        6'h2B: begin alu_is_cmp = 1'b1; alu_cmp = a < b; alu_res = WIDTH'(alu_cmp); end
        6'h00: alu_res = b << shamt;
        6'h02: alu_res = b >> shamt;
        6'h03: alu_res = $signed(b) >>> shamt;
        6'h04: alu_res = b << vamt;
        6'h06: alu_res = b >> vamt;
        6'h07: alu_res = $signed(b) >>> vamt;
        6'h10: alu_res = hi_q;
        6'h12: alu_res = lo_q;
        6'h18: begin kind = K_MUL; is_signed = 1'b1; end
        6'h19: kind = K_MUL;
        6'h1A: begin kind = K_DIV; is_signed = 1'b1; end
        6'h1B: kind = K_DIV;
        default: alu_ill = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'h08: begin alu_res = addi_res; alu_ovf = addi_ovf; end
        6'h09, 6'h23, 6'h2B: alu_res = addi_res;
        6'h0A: begin alu_is_cmp = 1'b1; alu_cmp = $signed(a) < $signed(simm); alu_res = WIDTH'(alu_cmp); end
        6'h04, 6'h05: alu_res = sub_res;
        6'h0C: alu_res = a & zimm;
        6'h0D: alu_res = a | zimm;
        6'h0E: alu_res = a ^ zimm;
        default: alu_ill = 1'b1;
      endcase
    end
  end

  // An illegal op reports all-zero flags even though its result reads as zero.
  assign alu_flags = alu_ill ? 3'b000
                   : {alu_res == '0, alu_is_cmp ? alu_cmp : alu_res[WIDTH-1], alu_ovf};

  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
  logic [2*WIDTH-1:0] mul_prod, mul_final;

  assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
  assign mul_hi_n  = mul_sum[WIDTH:1];
  assign mul_lo_n  = {mul_sum[0], work_lo[WIDTH-1:1]};
  assign mul_prod  = {mul_hi_n, mul_lo_n};
  assign mul_final = neg_lo ? -mul_prod : mul_prod;

  assign div_shift = {work_hi, work_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, operand};
  assign div_hi_n  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_lo_n  = {work_lo[WIDTH-2:0], ~div_diff[WIDTH]};

  logic [WIDTH-1:0] div_q, div_r;
  logic             div_v;

  always_comb begin
    div_q = neg_lo ? -div_lo_n : div_lo_n;
    div_r = neg_hi ? -div_hi_n : div_hi_n;
    div_v = 1'b0;
    if (div_zero) begin
      div_q = '1;
      div_r = dividend;
      div_v = 1'b1;
    end else if (div_ovf) begin
      div_q = MOST_NEG;
      div_r = '0;
      div_v = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      operand     <= '0;
      dividend    <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      div_zero    <= 1'b0;
      div_ovf     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 3'b000;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            case (kind)
              K_MUL: begin
                work_hi <= '0;
                work_lo <= mag_b;
                operand <= mag_a;
                neg_lo  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                cnt     <= CW'(WIDTH - 1);
                state   <= MUL;
              end
              K_DIV: begin
                work_hi  <= '0;
                work_lo  <= mag_a;
                operand  <= mag_b;
                dividend <= a;
                neg_lo   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi   <= is_signed && a[WIDTH-1];
                div_zero <= (b == '0);
                div_ovf  <= is_signed && (a == MOST_NEG) && (b == '1);
                cnt      <= CW'(WIDTH - 1);
                state    <= DIV;
              end
              default: begin
                result_q    <= alu_res;
                flags_q     <= alu_flags;
                illegal_q   <= alu_ill;
                out_valid_q <= 1'b1;
                state       <= DONE;
              end
            endcase
          end
        end
        MUL: begin
          work_hi <= mul_hi_n;
          work_lo <= mul_lo_n;
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            hi_q        <= mul_final[2*WIDTH-1:WIDTH];
            lo_q        <= mul_final[WIDTH-1:0];
            result_q    <= mul_final[WIDTH-1:0];
            flags_q     <= {mul_final == '0, mul_final[2*WIDTH-1], 1'b0};
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DIV: begin
          work_hi <= div_hi_n;
          work_lo <= div_lo_n;
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            hi_q        <= div_r;
            lo_q        <= div_q;
            result_q    <= div_q;
            flags_q     <= {{div_r, div_q} == '0, div_r[WIDTH-1], div_v};
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.result_out = result_q;
  assign bus.flags      = flags_q;
  assign bus.illegal    = illegal_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
endmodule
